h264_mb_fetch: RTL and testbench

- Upstream stage of the encoder core. Walks a planar YUV 4:2:0 frame in raster macroblock order and issues 32-bit word reads to frame memory.
- Packs each macroblock's 96 words (64 Y, 16 U, 16 V) into a local buffer.
- Presents the buffered MB to the downstream intra/transform stage through a registered read port with a valid/release handshake.

---
 rtl/h264_mb_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_h264_mb_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_mb_fetch.sv
// Raster-order macroblock fetcher: reads 96 words per YUV 4:2:0 MB into a local buffer.
// Define H264_MB_FETCH_PINGPONG_EN for a two-bank buffer that overlaps fetch with downstream use.
module h264_mb_fetch #(
  parameter logic [31:0] Y_BASE = 32'd0,
  parameter logic [31:0] U_BASE = 32'd64,
  parameter logic [31:0] V_BASE = 32'd80
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [5:0]  i_frame_w_mb,
  input  logic [5:0]  i_frame_h_mb,
  output logic        o_fetch_req,
  output logic [31:0] o_fetch_addr,
  input  logic [31:0] i_data_word,
  input  logic        i_data_valid,
  output logic        o_mb_valid,
  output logic [5:0]  o_mb_x,
  output logic [5:0]  o_mb_y,
  input  logic [6:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  input  logic        i_mb_release,
  output logic        o_busy,
  output logic        o_frame_done
);

`ifdef H264_MB_FETCH_PINGPONG_EN
  localparam logic PP        = 1'b1;
  localparam int   BUF_WORDS = 192;
  localparam int   IW        = 8;
`else
  localparam logic PP        = 1'b0;
  localparam int   BUF_WORDS = 96;
  localparam int   IW        = 7;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
  state_t r_state, w_next_state;

  logic [5:0]  r_w, r_h, r_x, r_y;
  logic [6:0]  r_cnt;
  logic [31:0] r_addr, r_row;
  logic [31:0] r_mb_y, r_mb_u, r_mb_v;
  logic [31:0] r_line_y, r_line_u, r_line_v;
  logic [1:0]  r_full, r_last;
  logic        r_fill_bank, r_pres_bank;
  logic [5:0]  r_bank_x [2];
  logic [5:0]  r_bank_y [2];
  logic        r_frame_done;
  logic [31:0] r_rd_data;
  logic [31:0] r_buf [BUF_WORDS];

  logic          w_xfer, w_last_word, w_last_col, w_last_mb;
  logic          w_release, w_rel_last, w_dims_ok, w_start_ok;
  logic [31:0]   w_stride_y, w_stride_c;
  logic [31:0]   w_next_line_y, w_next_line_u, w_next_line_v;
  logic [31:0]   w_next_mb_y, w_next_mb_u, w_next_mb_v;
  logic [31:0]   w_next_addr, w_next_row;
  logic [IW-1:0] w_wr_idx, w_rd_idx;

  assign w_xfer      = o_fetch_req && i_data_valid;
  assign w_last_word = (r_cnt == 7'd95);
  assign w_last_col  = (r_x == r_w - 6'd1);
  assign w_last_mb   = w_last_col && (r_y == r_h - 6'd1);
  assign w_release   = i_mb_release && o_mb_valid;
  assign w_rel_last  = w_release && r_last[r_pres_bank];
  assign w_dims_ok   = (i_frame_w_mb != 6'd0) && (i_frame_h_mb != 6'd0);
  assign w_start_ok  = (r_state == S_IDLE) && i_start && w_dims_ok;

  // Strides and MB-row steps are shifts of the latched width, so no multipliers are needed.
  assign w_stride_y    = {24'd0, r_w, 2'd0};
  assign w_stride_c    = {25'd0, r_w, 1'b0};
  assign w_next_line_y = r_line_y + {20'd0, r_w, 6'd0};
  assign w_next_line_u = r_line_u + {22'd0, r_w, 4'd0};
  assign w_next_line_v = r_line_v + {22'd0, r_w, 4'd0};
  assign w_next_mb_y   = w_last_col ? w_next_line_y : r_mb_y + 32'd4;
  assign w_next_mb_u   = w_last_col ? w_next_line_u : r_mb_u + 32'd2;
  assign w_next_mb_v   = w_last_col ? w_next_line_v : r_mb_v + 32'd2;

`ifdef H264_MB_FETCH_PINGPONG_EN
  assign w_wr_idx = r_fill_bank ? ({1'b0, r_cnt} + 8'd96) : {1'b0, r_cnt};
  assign w_rd_idx = r_pres_bank ? ({1'b0, i_rd_addr} + 8'd96) : {1'b0, i_rd_addr};
`else
  assign w_wr_idx = r_cnt;
  assign w_rd_idx = i_rd_addr;
`endif

  always_comb begin
    w_next_addr = r_addr + 32'd1;
    w_next_row  = r_row;
    if (r_cnt == 7'd63) begin
      w_next_addr = r_mb_u;
      w_next_row  = r_mb_u;
    end else if (r_cnt == 7'd79) begin
      w_next_addr = r_mb_v;
      w_next_row  = r_mb_v;
    end else if ((r_cnt < 7'd64) && (r_cnt[1:0] == 2'd3)) begin
      w_next_row  = r_row + w_stride_y;
      w_next_addr = w_next_row;
    end else if ((r_cnt >= 7'd64) && r_cnt[0]) begin
      w_next_row  = r_row + w_stride_c;
      w_next_addr = w_next_row;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_FETCH;
      S_FETCH: if (w_xfer && w_last_word && w_last_mb) w_next_state = S_DRAIN;
      S_DRAIN: if (w_rel_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fetch stalls whenever the bank being filled still holds an unreleased MB.
  always_comb begin
    o_fetch_req  = (r_state == S_FETCH) && !r_full[r_fill_bank];
    o_fetch_addr = r_addr;
    o_busy       = (r_state != S_IDLE);
    o_mb_valid   = r_full[r_pres_bank];
    o_mb_x       = r_bank_x[r_pres_bank];
    o_mb_y       = r_bank_y[r_pres_bank];
    o_rd_data    = r_rd_data;
    o_frame_done = r_frame_done;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_w <= '0; r_h <= '0; r_x <= '0; r_y <= '0;
      r_cnt <= '0; r_addr <= '0; r_row <= '0;
      r_mb_y <= '0; r_mb_u <= '0; r_mb_v <= '0;
      r_line_y <= '0; r_line_u <= '0; r_line_v <= '0;
      r_full <= '0; r_last <= '0;
      r_fill_bank <= 1'b0; r_pres_bank <= 1'b0;
      r_bank_x[0] <= '0; r_bank_x[1] <= '0;
      r_bank_y[0] <= '0; r_bank_y[1] <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if ((r_state == S_IDLE) && i_start) begin
        if (w_dims_ok) begin
          r_w <= i_frame_w_mb; r_h <= i_frame_h_mb;
          r_x <= '0; r_y <= '0; r_cnt <= '0;
          r_addr <= Y_BASE; r_row <= Y_BASE;
          r_mb_y <= Y_BASE; r_mb_u <= U_BASE; r_mb_v <= V_BASE;
          r_line_y <= Y_BASE; r_line_u <= U_BASE; r_line_v <= V_BASE;
          r_full <= '0; r_last <= '0;
          r_fill_bank <= 1'b0; r_pres_bank <= 1'b0;
        end else begin
          r_frame_done <= 1'b1;
        end
      end
      if (w_xfer) begin
        if (w_last_word) begin
          r_full[r_fill_bank]   <= 1'b1;
          r_last[r_fill_bank]   <= w_last_mb;
          r_bank_x[r_fill_bank] <= r_x;
          r_bank_y[r_fill_bank] <= r_y;
          r_fill_bank <= r_fill_bank ^ PP;
          r_cnt <= '0;
          if (!w_last_mb) begin
            r_x    <= w_last_col ? 6'd0 : r_x + 6'd1;
            r_y    <= w_last_col ? r_y + 6'd1 : r_y;
            r_mb_y <= w_next_mb_y; r_mb_u <= w_next_mb_u; r_mb_v <= w_next_mb_v;
            r_addr <= w_next_mb_y; r_row  <= w_next_mb_y;
            if (w_last_col) begin
              r_line_y <= w_next_line_y; r_line_u <= w_next_line_u; r_line_v <= w_next_line_v;
            end
          end
        end else begin
          r_cnt  <= r_cnt + 7'd1;
          r_addr <= w_next_addr;
          r_row  <= w_next_row;
        end
      end
      if (w_release) begin
        r_full[r_pres_bank] <= 1'b0;
        r_pres_bank <= r_pres_bank ^ PP;
        if (w_rel_last) r_frame_done <= 1'b1;
      end
    end
  end

  // Buffer contents carry no reset; they are always rewritten before being presented.
  always_ff @(posedge i_clk) begin
    if (w_xfer) r_buf[w_wr_idx] <= i_data_word;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_rd_data <= '0;
    else if (i_rd_addr < 7'd96)  r_rd_data <= r_buf[w_rd_idx];
    else                         r_rd_data <= '0;
  end

endmodule

// File: tb/tb_h264_mb_fetch.sv
// Directed bench for h264_mb_fetch: memory returns fetch address plus a per-test salt.
module tb_h264_mb_fetch;

  logic        clk = 1'b0;
  logic        rst, start, fetchReq, dataValid, mbValid, mbRelease, busy, frameDone;
  logic [5:0]  frameW, frameH, mbX, mbY;
  logic [31:0] fetchAddr, dataWord, rdData, salt;
  logic [6:0]  rdAddr;

  always #5 clk = ~clk;

  // Memory model: each word's content is its address offset by the test's salt.
  assign dataWord = fetchAddr + salt;

  h264_mb_fetch dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_frame_w_mb(frameW), .i_frame_h_mb(frameH),
    .o_fetch_req(fetchReq), .o_fetch_addr(fetchAddr),
    .i_data_word(dataWord), .i_data_valid(dataValid),
    .o_mb_valid(mbValid), .o_mb_x(mbX), .o_mb_y(mbY),
    .i_rd_addr(rdAddr), .o_rd_data(rdData),
    .i_mb_release(mbRelease), .o_busy(busy), .o_frame_done(frameDone)
  );

  logic [31:0] capQ[$];
  int          reqSeen = 0;

  // Log every completed transfer and every requesting cycle.
  always @(posedge clk) begin
    if (fetchReq && dataValid) capQ.push_back(fetchAddr);
    if (fetchReq) reqSeen++;
  end

  typedef struct { logic [6:0] addr; logic [31:0] exp; } rdVec_t;
  typedef struct { int idx; logic [31:0] addr; } addrVec_t;
  typedef struct { logic [5:0] x; logic [5:0] y; logic [31:0] yA; logic [31:0] uA; logic [31:0] vA; } mbVec_t;

  rdVec_t   rdTab[6];
  addrVec_t addrTab[10];
  mbVec_t   mbTab[4];

  int testsRun = 0;
  int testsFailed = 0;
  int capBase, reqCycles, holdErr, seqErr, reqBase;
  bit reached;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] w, input logic [5:0] h);
    start  = s;
    frameW = w;
    frameH = h;
  endtask

  task automatic startFrame(input logic [5:0] w, input logic [5:0] h);
    @(negedge clk);
    applyStimulus(1'b1, w, h);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge where fetch_req first shows; leaves at the negedge where mb_valid is seen.
  task automatic runFetch(input bit toggle, output int reqs, output int holds);
    bit phase, prevLow, done;
    logic [31:0] held;
    phase = 1'b0; prevLow = 1'b0; done = 1'b0; held = '0; reqs = 0; holds = 0;
    for (int c = 0; c < 1000; c++) begin
      if (mbValid) begin done = 1'b1; break; end
      if (prevLow && (fetchAddr !== held)) holds++;
      prevLow = 1'b0;
      if (fetchReq) begin
        reqs++;
        dataValid = toggle ? phase : 1'b1;
        phase = ~phase;
        if (!dataValid) begin prevLow = 1'b1; held = fetchAddr; end
      end
      @(negedge clk);
    end
    dataValid = 1'b1;
    checkOutput("fetch_done_in_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic waitValid(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (mbValid) begin done = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic readWord(input logic [6:0] a, input logic [31:0] exp);
    @(negedge clk);
    rdAddr = a;
    @(negedge clk);
    checkOutput($sformatf("rd_data[%0d]", a), rdData, exp);
  endtask

  task automatic releaseMb();
    @(negedge clk);
    mbRelease = 1'b1;
    @(negedge clk);
    mbRelease = 1'b0;
  endtask

  // Expect one 1x1 MB at default bases: transfers base..base+95 carry addresses 0..95.
  task automatic checkSeq1x1(input string name, input int base);
    int errs;
    errs = 0;
    checkOutput({name, "_count"}, capQ.size() - base, 32'd96);
    for (int i = 0; i < 96; i++)
      if ((base + i >= capQ.size()) || (capQ[base + i] !== 32'(i))) errs++;
    checkOutput({name, "_seq"}, errs, 32'd0);
  endtask

  initial begin
    rdTab[0] = '{addr: 7'd0,   exp: 32'd0};
    rdTab[1] = '{addr: 7'd70,  exp: 32'd70};
    rdTab[2] = '{addr: 7'd95,  exp: 32'd95};
    rdTab[3] = '{addr: 7'd64,  exp: 32'd64};
    rdTab[4] = '{addr: 7'd96,  exp: 32'd0};
    rdTab[5] = '{addr: 7'd127, exp: 32'd0};

    addrTab[0] = '{idx: 96,  addr: 32'd4};
    addrTab[1] = '{idx: 99,  addr: 32'd7};
    addrTab[2] = '{idx: 100, addr: 32'd12};
    addrTab[3] = '{idx: 159, addr: 32'd127};
    addrTab[4] = '{idx: 160, addr: 32'd66};
    addrTab[5] = '{idx: 162, addr: 32'd70};
    addrTab[6] = '{idx: 196, addr: 32'd136};
    addrTab[7] = '{idx: 256, addr: 32'd96};
    addrTab[8] = '{idx: 288, addr: 32'd132};
    addrTab[9] = '{idx: 383, addr: 32'd143};

    mbTab[0] = '{x: 6'd0, y: 6'd0, yA: 32'd0,   uA: 32'd64, vA: 32'd80};
    mbTab[1] = '{x: 6'd1, y: 6'd0, yA: 32'd4,   uA: 32'd66, vA: 32'd82};
    mbTab[2] = '{x: 6'd0, y: 6'd1, yA: 32'd128, uA: 32'd96, vA: 32'd112};
    mbTab[3] = '{x: 6'd1, y: 6'd1, yA: 32'd132, uA: 32'd98, vA: 32'd114};

    rst = 1'b1; dataValid = 1'b0; rdAddr = '0; mbRelease = 1'b0; salt = '0;
    applyStimulus(1'b0, 6'd0, 6'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_fetch_req", {31'd0, fetchReq}, 32'd0);
    checkOutput("reset_fetch_addr", fetchAddr, 32'd0);
    checkOutput("reset_mb_valid", {31'd0, mbValid}, 32'd0);
    checkOutput("reset_mb_xy", {20'd0, mbX, mbY}, 32'd0);
    checkOutput("reset_rd_data", rdData, 32'd0);
    checkOutput("reset_busy_done", {30'd0, busy, frameDone}, 32'd0);

    // 1x1 frame, data_valid always high.
    $display("[TB] 1x1 frame, continuous data");
    salt = '0; dataValid = 1'b1; capBase = capQ.size();
    startFrame(6'd1, 6'd1);
    runFetch(1'b0, reqCycles, holdErr);
    checkOutput("t1_req_cycles", reqCycles, 32'd96);
    checkSeq1x1("t1_addr", capBase);
    checkOutput("t1_mb_xy", {20'd0, mbX, mbY}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 6; i++) readWord(rdTab[i].addr, rdTab[i].exp);
    releaseMb();
    checkOutput("t1_frame_done", {31'd0, frameDone}, 32'd1);
    checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("t1_mb_valid_after", {31'd0, mbValid}, 32'd0);
    @(negedge clk);
    checkOutput("t1_frame_done_pulse", {31'd0, frameDone}, 32'd0);

    // 2x2 frame with start held high and dimensions changed mid-frame.
    $display("[TB] 2x2 frame, start held during fetch");
    salt = 32'h1000_0000; dataValid = 1'b1; capBase = capQ.size();
    @(negedge clk);
    applyStimulus(1'b1, 6'd2, 6'd2);
    @(negedge clk);
    frameW = 6'd1; frameH = 6'd1;
    for (int m = 0; m < 4; m++) begin
      waitValid($sformatf("t2_mb%0d_valid", m));
      checkOutput($sformatf("t2_mb%0d_xy", m), {20'd0, mbX, mbY}, {20'd0, mbTab[m].x, mbTab[m].y});
      readWord(7'd0,  mbTab[m].yA + salt);
      readWord(7'd64, mbTab[m].uA + salt);
      readWord(7'd80, mbTab[m].vA + salt);
      if (m == 3) start = 1'b0;
      releaseMb();
    end
    checkOutput("t2_frame_done", {31'd0, frameDone}, 32'd1);
    checkOutput("t2_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("t2_xfer_count", capQ.size() - capBase, 32'd384);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("t2_addr[%0d]", addrTab[i].idx),
                  (capBase + addrTab[i].idx < capQ.size()) ? capQ[capBase + addrTab[i].idx] : 32'hFFFF_FFFF,
                  addrTab[i].addr);

    // 1x1 frame with data_valid alternating 0,1.
    $display("[TB] 1x1 frame, data_valid toggling");
    salt = 32'h0000_A000; capBase = capQ.size();
    startFrame(6'd1, 6'd1);
    runFetch(1'b1, reqCycles, holdErr);
    checkOutput("t3_req_cycles", reqCycles, 32'd192);
    checkOutput("t3_addr_hold", holdErr, 32'd0);
    checkSeq1x1("t3_addr", capBase);
    readWord(7'd33, 32'd33 + salt);
    readWord(7'd88, 32'd88 + salt);
    releaseMb();
    checkOutput("t3_frame_done", {31'd0, frameDone}, 32'd1);

    // Asynchronous reset part-way through a fetch, then a clean restart.
    $display("[TB] reset at count 40");
    salt = 32'h0000_5000; dataValid = 1'b1; rdAddr = 7'd10; capBase = capQ.size();
    startFrame(6'd1, 6'd1);
    reached = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (capQ.size() - capBase >= 40) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("t4_reached_40", {31'd0, reached}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_rst_fetch", {31'd0, fetchReq}, 32'd0);
    checkOutput("t4_rst_addr", fetchAddr, 32'd0);
    checkOutput("t4_rst_busy_valid", {30'd0, busy, mbValid}, 32'd0);
    checkOutput("t4_rst_rd_data", rdData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    capBase = capQ.size();
    startFrame(6'd1, 6'd1);
    runFetch(1'b0, reqCycles, holdErr);
    checkOutput("t4_req_cycles", reqCycles, 32'd96);
    checkSeq1x1("t4_addr", capBase);
    readWord(7'd40, 32'd40 + salt);
    releaseMb();
    checkOutput("t4_frame_done", {31'd0, frameDone}, 32'd1);

    // Zero-sized frames: immediate frame_done, no fetch.
    $display("[TB] zero-dimension starts");
    reqBase = reqSeen;
    @(negedge clk);
    applyStimulus(1'b1, 6'd0, 6'd3);
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_w0_frame_done", {31'd0, frameDone}, 32'd1);
    checkOutput("t5_w0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("t5_w0_done_pulse", {31'd0, frameDone}, 32'd0);
    applyStimulus(1'b1, 6'd3, 6'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_h0_frame_done", {31'd0, frameDone}, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("t5_no_fetch", reqSeen - reqBase, 32'd0);

`ifdef H264_MB_FETCH_PINGPONG_EN
    // 2x1 frame with release withheld: second MB fills the other bank.
    $display("[TB] ping-pong 2x1 frame");
    salt = 32'h2000_0000; dataValid = 1'b1; capBase = capQ.size();
    startFrame(6'd2, 6'd1);
    reached = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (capQ.size() - capBase >= 192) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("t6_both_filled", {31'd0, reached}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t6_stalled", {31'd0, fetchReq}, 32'd0);
    checkOutput("t6_first_xy", {25'd0, mbValid, mbX}, {25'd0, 1'b1, 6'd0});
    checkOutput("t6_mb1_first_addr", capQ[capBase + 96], 32'd4);
    readWord(7'd0, 32'd0 + salt);
    releaseMb();
    checkOutput("t6_second_xy", {25'd0, mbValid, mbX}, {25'd0, 1'b1, 6'd1});
    readWord(7'd0, 32'd4 + salt);
    readWord(7'd64, 32'd66 + salt);
    releaseMb();
    checkOutput("t6_frame_done", {31'd0, frameDone}, 32'd1);
    checkOutput("t6_mb_valid_after", {31'd0, mbValid}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
